lsu_mem_stage: RTL and testbench

LSU_MEM_STAGE -- requirements
Module: lsu_mem_stage

---
 rtl/lsu_pkg.sv | 50 +++++
 rtl/load_extend.sv | 25 ++
 rtl/lsu_mem_stage.sv | 154 +++++++++++++++
 tb/tb_lsu_mem_stage.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared encodings for the LSU memory stage: funct3 size codes, cache write
// byte-enable codes, exception causes and FSM states.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;

  localparam logic [7:0] WR_NONE = 8'h00;
  localparam logic [7:0] WR_B    = 8'h01;
  localparam logic [7:0] WR_H    = 8'h03;
  localparam logic [7:0] WR_W    = 8'h0F;
  localparam logic [7:0] WR_D    = 8'hFF;

  localparam logic [1:0] EXC_MISALIGN = 2'd1;
  localparam logic [1:0] EXC_FAULT    = 2'd2;
  localparam logic [1:0] EXC_TIMEOUT  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2,
    ST_ERR  = 2'd3
  } lsu_state_e;

  // Store byte-enable code from the access size held in funct3[1:0].
  function automatic logic [7:0] wr_code(input logic [2:0] f3);
    case (f3[1:0])
      2'd0:    wr_code = WR_B;
      2'd1:    wr_code = WR_H;
      2'd2:    wr_code = WR_W;
      default: wr_code = WR_D;
    endcase
  endfunction

  // True when the low address bits are not a multiple of the access size.
  function automatic logic is_misaligned(input logic [2:0] f3, input logic [2:0] addr_lo);
    case (f3[1:0])
      2'd0:    is_misaligned = 1'b0;
      2'd1:    is_misaligned = (addr_lo[0] != 1'b0);
      2'd2:    is_misaligned = (addr_lo[1:0] != 2'b00);
      default: is_misaligned = (addr_lo != 3'b000);
    endcase
  endfunction

endpackage

// File: rtl/load_extend.sv
// Combinational sign/zero extender for load data, selected by funct3.
module load_extend
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [63:0] raw,
  output logic [63:0] ext
);

  // funct3 3'b111 has no defined load and is returned as a full doubleword.
  always_comb begin
    ext = raw;
    case (funct3)
      F3_B:    ext = {{56{raw[7]}},  raw[7:0]};
      F3_H:    ext = {{48{raw[15]}}, raw[15:0]};
      F3_W:    ext = {{32{raw[31]}}, raw[31:0]};
      F3_D:    ext = raw;
      F3_BU:   ext = {56'd0, raw[7:0]};
      F3_HU:   ext = {48'd0, raw[15:0]};
      F3_WU:   ext = {32'd0, raw[31:0]};
      default: ext = raw;
    endcase
  end

endmodule

// File: rtl/lsu_mem_stage.sv
// RV64I load/store MEM stage: checks alignment and range, runs one cache
// request per instruction, extends load data and reports timeouts.
module lsu_mem_stage
  import lsu_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  input  logic              is_load,
  input  logic              is_store,
  input  logic [2:0]        funct3,
  input  logic [63:0]       eff_addr,
  input  logic [63:0]       store_data,
  input  logic [4:0]        rd_idx,
  output logic [ADDR_W-1:0] address,
  output logic [63:0]       data_in_cpu,
  output logic              rd,
  output logic [7:0]        wr,
  input  logic              data_ready,
  input  logic [63:0]       data2cpu,
  output logic              stall,
  output logic              wb_valid,
  output logic [63:0]       wb_data,
  output logic [4:0]        wb_rd,
  output logic              exc_valid,
  output logic [1:0]        exc_cause
);

  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  lsu_state_e        state_r;
  logic [CNT_W-1:0]  cnt_r;
  logic [ADDR_W-1:0] address_r;
  logic [63:0]       data_in_cpu_r;
  logic [63:0]       wb_data_r;
  logic              rd_r;
  logic [7:0]        wr_r;
  logic              wb_valid_r;
  logic [4:0]        wb_rd_r;
  logic              exc_valid_r;
  logic [1:0]        exc_cause_r;
  logic              is_load_r;
  logic [2:0]        funct3_r;
  logic [4:0]        rd_idx_r;

  logic              accept_s;
  logic              misalign_s;
  logic              fault_s;
  logic              timeout_s;
  logic [63:0]       ext_s;

  assign accept_s   = req_valid & (is_load | is_store);
  assign misalign_s = is_misaligned(funct3, eff_addr[2:0]);
  assign fault_s    = ((eff_addr >> ADDR_W) != 64'd0);
  assign timeout_s  = (cnt_r == CNT_W'(TIMEOUT - 1));

  // Gated by rst_n so the pipeline is released the instant reset asserts.
  assign stall = rst_n & (((state_r == ST_IDLE) & accept_s & ~misalign_s & ~fault_s)
                          | (state_r == ST_REQ));

  load_extend u_load_extend (
    .funct3 (funct3_r),
    .raw    (data2cpu),
    .ext    (ext_s)
  );

  // Access sequencer: accept/check in IDLE, hold the request in REQ, one-cycle RESP/ERR.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= ST_IDLE;
      cnt_r         <= '0;
      address_r     <= '0;
      data_in_cpu_r <= 64'd0;
      rd_r          <= 1'b0;
      wr_r          <= WR_NONE;
      wb_valid_r    <= 1'b0;
      wb_data_r     <= 64'd0;
      wb_rd_r       <= 5'd0;
      exc_valid_r   <= 1'b0;
      exc_cause_r   <= 2'd0;
      is_load_r     <= 1'b0;
      funct3_r      <= 3'd0;
      rd_idx_r      <= 5'd0;
    end else begin
      wb_valid_r  <= 1'b0;
      exc_valid_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (accept_s && misalign_s) begin
            state_r     <= ST_ERR;
            exc_valid_r <= 1'b1;
            exc_cause_r <= EXC_MISALIGN;
          end else if (accept_s && fault_s) begin
            state_r     <= ST_ERR;
            exc_valid_r <= 1'b1;
            exc_cause_r <= EXC_FAULT;
          end else if (accept_s) begin
            state_r       <= ST_REQ;
            cnt_r         <= '0;
            address_r     <= eff_addr[ADDR_W-1:0];
            data_in_cpu_r <= store_data;
            rd_r          <= is_load;
            wr_r          <= is_load ? WR_NONE : wr_code(funct3);
            is_load_r     <= is_load;
            funct3_r      <= funct3;
            rd_idx_r      <= rd_idx;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_REQ: begin
          // data_ready takes precedence over a coincident timeout.
          if (data_ready) begin
            state_r <= ST_RESP;
            rd_r    <= 1'b0;
            wr_r    <= WR_NONE;
            if (is_load_r) begin
              wb_valid_r <= 1'b1;
              wb_data_r  <= ext_s;
              wb_rd_r    <= rd_idx_r;
            end else begin
              wb_valid_r <= 1'b0;
            end
          end else if (timeout_s) begin
            state_r     <= ST_ERR;
            rd_r        <= 1'b0;
            wr_r        <= WR_NONE;
            exc_valid_r <= 1'b1;
            exc_cause_r <= EXC_TIMEOUT;
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        ST_RESP: state_r <= ST_IDLE;
        ST_ERR:  state_r <= ST_IDLE;
        default: state_r <= ST_IDLE;
      endcase
    end
  end

  assign address     = address_r;
  assign data_in_cpu = data_in_cpu_r;
  assign rd          = rd_r;
  assign wr          = wr_r;
  assign wb_valid    = wb_valid_r;
  assign wb_data     = wb_data_r;
  assign wb_rd       = wb_rd_r;
  assign exc_valid   = exc_valid_r;
  assign exc_cause   = exc_cause_r;

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Self-checking bench for lsu_mem_stage: directed scenarios plus randomized
// accesses against a size/range based reference model.
module tb_lsu_mem_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0, is_load = 1'b0, is_store = 1'b0;
  logic [2:0]  funct3 = 3'd0;
  logic [63:0] eff_addr = 64'd0, store_data = 64'd0;
  logic [4:0]  rd_idx = 5'd0;
  logic [31:0] address;
  logic [63:0] data_in_cpu;
  logic        rd;
  logic [7:0]  wr;
  logic        data_ready = 1'b0;
  logic [63:0] data2cpu = 64'd0;
  logic        stall, wb_valid, exc_valid;
  logic [63:0] wb_data;
  logic [4:0]  wb_rd;
  logic [1:0]  exc_cause;

  int chk_n = 0;
  int pass_n = 0;

  always #5 clk = ~clk;

  lsu_mem_stage dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .is_load(is_load),
    .is_store(is_store), .funct3(funct3), .eff_addr(eff_addr),
    .store_data(store_data), .rd_idx(rd_idx), .address(address),
    .data_in_cpu(data_in_cpu), .rd(rd), .wr(wr), .data_ready(data_ready),
    .data2cpu(data2cpu), .stall(stall), .wb_valid(wb_valid), .wb_data(wb_data),
    .wb_rd(wb_rd), .exc_valid(exc_valid), .exc_cause(exc_cause)
  );

  typedef struct {
    int          stall_n, req_n, wb_n, wb_cyc, exc_n, exc_cyc, late_req, unstable, timeout;
    logic [63:0] wb_data, dic;
    logic [4:0]  wb_rd;
    logic [1:0]  cause;
    logic [31:0] addr;
    logic        rd;
    logic [7:0]  wr;
  } obs_t;

  // Reference load extension: mask to the access width, then sign-fill if signed.
  function automatic logic [63:0] exp_ext(input logic [2:0] f3, input logic [63:0] d);
    int bits;
    logic [63:0] mask, v;
    bits = 8 * (1 << f3[1:0]);
    mask = (bits == 64) ? ~64'd0 : ((64'd1 << bits) - 64'd1);
    v = d & mask;
    if (f3[2] == 1'b0 && bits < 64 && d[bits-1]) v = v | ~mask;
    return v;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  // Presents one instruction as a stalling pipeline would and plays a cache
  // that raises data_ready in the lat-th request cycle (lat=0: never).
  task automatic run_access(input logic ld, input logic st, input logic [2:0] f3,
                            input logic [63:0] addr, input logic [63:0] sd,
                            input logic [4:0] ridx, input int lat,
                            input logic [63:0] dat, input logic spur, output obs_t o);
    logic present, prev_dr, busy, done;
    int post;
    o = '{default: 0};
    present = 1'b1; prev_dr = 1'b0; post = 0; done = 1'b0;
    for (int c = 0; c < 200; c++) begin
      busy = rd | (wr != 8'h00);
      if (wb_valid) begin o.wb_n++; o.wb_cyc = c; o.wb_data = wb_data; o.wb_rd = wb_rd; end
      if (exc_valid) begin o.exc_n++; o.exc_cyc = c; o.cause = exc_cause; end
      if (prev_dr && busy) o.late_req++;
      if (busy) begin
        o.req_n++;
        if (o.req_n == 1) begin o.addr = address; o.dic = data_in_cpu; o.rd = rd; o.wr = wr; end
        else if (address !== o.addr || data_in_cpu !== o.dic || rd !== o.rd || wr !== o.wr) o.unstable++;
      end
      prev_dr = busy && (o.req_n == lat);
      data_ready = prev_dr ? 1'b1 : (!busy && spur && ($urandom_range(0, 1) == 1));
      data2cpu = prev_dr ? dat : {$urandom, $urandom};
      req_valid = present; is_load = ld; is_store = st; funct3 = f3;
      eff_addr = addr; store_data = sd; rd_idx = ridx;
      #1;
      if (stall) o.stall_n++;
      else if (present) present = 1'b0;
      else post++;
      cyc();
      if (post >= 2) begin done = 1'b1; break; end
    end
    data_ready = 1'b0; req_valid = 1'b0;
    if (!done) o.timeout = 1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = 1'b1; is_load = 1'b1; funct3 = 3'd3; eff_addr = 64'h100;
    cyc(); cyc();
    chk_n++; if ({rd, wr, wb_valid, exc_valid, exc_cause, wb_rd} !== 18'd0)
      $display("FAIL reset_ctrl got %h want 0", {rd, wr, wb_valid, exc_valid, exc_cause, wb_rd}); else pass_n++;
    chk_n++; if ((address | data_in_cpu | wb_data) !== 64'd0)
      $display("FAIL reset_data got %h/%h/%h want 0", address, data_in_cpu, wb_data); else pass_n++;
    chk_n++; if (stall !== 1'b0) $display("FAIL reset_stall got %b want 0", stall); else pass_n++;
    req_valid = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic test_load_basic();
    obs_t o;
    run_access(1'b1, 1'b0, 3'b011, 64'h100, 64'd0, 5'd7, 3, 64'h8000_0000_0000_0001, 1'b0, o);
    chk_n++; if (o.timeout !== 0) $display("FAIL ld_done got timeout want completion"); else pass_n++;
    chk_n++; if (o.wb_n !== 1 || o.wb_cyc !== 4) $display("FAIL ld_wb got n=%0d cyc=%0d want n=1 cyc=4", o.wb_n, o.wb_cyc); else pass_n++;
    chk_n++; if (o.wb_data !== 64'h8000_0000_0000_0001 || o.wb_rd !== 5'd7)
      $display("FAIL ld_data got %h rd=%0d want 8000000000000001 rd=7", o.wb_data, o.wb_rd); else pass_n++;
    chk_n++; if (o.stall_n !== 4) $display("FAIL ld_stall got %0d want 4", o.stall_n); else pass_n++;
    chk_n++; if (o.addr !== 32'h100 || o.rd !== 1'b1 || o.wr !== 8'h00 || o.exc_n !== 0)
      $display("FAIL ld_req got addr=%h rd=%b wr=%h exc=%0d want 100/1/00/0", o.addr, o.rd, o.wr, o.exc_n); else pass_n++;
  endtask

  task automatic test_store();
    obs_t o;
    run_access(1'b0, 1'b1, 3'b000, 64'h203, 64'h1234_5678_9ABC_DEF0, 5'd3, 2, 64'd0, 1'b0, o);
    chk_n++; if (o.wr !== 8'h01 || o.rd !== 1'b0 || o.addr !== 32'h203)
      $display("FAIL sb_req got wr=%h rd=%b addr=%h want 01/0/203", o.wr, o.rd, o.addr); else pass_n++;
    chk_n++; if (o.dic !== 64'h1234_5678_9ABC_DEF0) $display("FAIL sb_data got %h want 123456789abcdef0", o.dic); else pass_n++;
    chk_n++; if (o.wb_n !== 0 || o.late_req !== 0 || o.unstable !== 0 || o.stall_n !== 3)
      $display("FAIL sb_seq got wb=%0d late=%0d unstable=%0d stall=%0d want 0/0/0/3", o.wb_n, o.late_req, o.unstable, o.stall_n); else pass_n++;
  endtask

  task automatic test_misalign();
    obs_t o;
    run_access(1'b1, 1'b0, 3'b001, 64'h101, 64'd0, 5'd1, 2, 64'd0, 1'b0, o);
    chk_n++; if (o.exc_n !== 1 || o.exc_cyc !== 1 || o.cause !== 2'd1)
      $display("FAIL lh_misalign got n=%0d cyc=%0d cause=%0d want 1/1/1", o.exc_n, o.exc_cyc, o.cause); else pass_n++;
    chk_n++; if (o.req_n !== 0 || o.stall_n !== 0 || o.wb_n !== 0)
      $display("FAIL lh_noreq got req=%0d stall=%0d wb=%0d want 0/0/0", o.req_n, o.stall_n, o.wb_n); else pass_n++;
  endtask

  task automatic test_fault_ext();
    obs_t o;
    run_access(1'b1, 1'b0, 3'b010, 64'h1_0000_0000, 64'd0, 5'd2, 2, 64'd0, 1'b0, o);
    chk_n++; if (o.exc_n !== 1 || o.cause !== 2'd2 || o.req_n !== 0)
      $display("FAIL lw_fault got n=%0d cause=%0d req=%0d want 1/2/0", o.exc_n, o.cause, o.req_n); else pass_n++;
    run_access(1'b1, 1'b0, 3'b110, 64'h40, 64'd0, 5'd4, 1, 64'hFFFF_FFFF_8000_0000, 1'b0, o);
    chk_n++; if (o.wb_data !== 64'h0000_0000_8000_0000) $display("FAIL lwu_ext got %h want 0000000080000000", o.wb_data); else pass_n++;
    run_access(1'b1, 1'b0, 3'b010, 64'h44, 64'd0, 5'd5, 1, 64'hFFFF_FFFF_8000_0000, 1'b0, o);
    chk_n++; if (o.wb_data !== 64'hFFFF_FFFF_8000_0000) $display("FAIL lw_ext got %h want ffffffff80000000", o.wb_data); else pass_n++;
  endtask

  task automatic test_timeout();
    obs_t o;
    run_access(1'b1, 1'b0, 3'b011, 64'h300, 64'd0, 5'd9, 0, 64'd0, 1'b0, o);
    chk_n++; if (o.exc_n !== 1 || o.cause !== 2'd3 || o.exc_cyc !== 65)
      $display("FAIL to_exc got n=%0d cause=%0d cyc=%0d want 1/3/65", o.exc_n, o.cause, o.exc_cyc); else pass_n++;
    chk_n++; if (o.req_n !== 64 || o.stall_n !== 65 || o.wb_n !== 0)
      $display("FAIL to_req got req=%0d stall=%0d wb=%0d want 64/65/0", o.req_n, o.stall_n, o.wb_n); else pass_n++;
    run_access(1'b1, 1'b0, 3'b011, 64'h308, 64'd0, 5'd10, 64, 64'h5A5A, 1'b0, o);
    chk_n++; if (o.exc_n !== 0 || o.wb_n !== 1 || o.wb_cyc !== 65 || o.wb_data !== 64'h5A5A)
      $display("FAIL to_edge got exc=%0d wb=%0d cyc=%0d data=%h want 0/1/65/5a5a", o.exc_n, o.wb_n, o.wb_cyc, o.wb_data); else pass_n++;
  endtask

  task automatic test_reset_mid_req();
    obs_t o;
    req_valid = 1'b1; is_load = 1'b1; is_store = 1'b0; funct3 = 3'd3; eff_addr = 64'h100; data_ready = 1'b0;
    cyc(); cyc();
    chk_n++; if (rd !== 1'b1) $display("FAIL mid_pre got rd=%b want 1", rd); else pass_n++;
    #1 rst_n = 1'b0;
    #1;
    chk_n++; if (rd !== 1'b0 || wr !== 8'h00 || stall !== 1'b0)
      $display("FAIL mid_rst got rd=%b wr=%h stall=%b want 0/00/0", rd, wr, stall); else pass_n++;
    chk_n++; if (address !== 32'd0 || wb_data !== 64'd0)
      $display("FAIL mid_clr got addr=%h wb_data=%h want 0/0", address, wb_data); else pass_n++;
    req_valid = 1'b0;
    cyc();
    rst_n = 1'b1;
    run_access(1'b0, 1'b1, 3'b011, 64'h8, 64'hCAFE_F00D_1234_5678, 5'd0, 2, 64'd0, 1'b0, o);
    chk_n++; if (o.wr !== 8'hFF || o.addr !== 32'h8 || o.exc_n !== 0 || o.stall_n !== 3 || o.late_req !== 0)
      $display("FAIL sd_after got wr=%h addr=%h exc=%0d stall=%0d late=%0d want ff/8/0/3/0", o.wr, o.addr, o.exc_n, o.stall_n, o.late_req); else pass_n++;
  endtask

  task automatic test_random();
    obs_t o;
    logic ld, st, acc, mis, flt;
    logic [2:0] f3;
    logic [63:0] addr, sd, dat, ew;
    logic [4:0] ridx;
    int lat, nb, e_req, e_stall, e_wb, e_exc;
    logic [1:0] e_cause;
    for (int n = 0; n < 80; n++) begin
      ld = 1'($urandom_range(0, 1));
      st = ld ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 15) != 0);
      f3 = ld ? 3'($urandom_range(0, 7)) : 3'($urandom_range(0, 3));
      nb = 1 << f3[1:0];
      case ($urandom_range(0, 7))
        0:       addr = {32'($urandom_range(1, 32'hFFFF_FFFF)), $urandom};
        1:       addr = {32'd0, $urandom};
        default: addr = {32'd0, $urandom} & ~(64'(nb) - 64'd1);
      endcase
      sd = {$urandom, $urandom}; dat = {$urandom, $urandom}; ridx = 5'($urandom);
      lat = ($urandom_range(0, 24) == 0) ? 0 : $urandom_range(1, 6);
      run_access(ld, st, f3, addr, sd, ridx, lat, dat, 1'b1, o);
      acc = ld | st;
      mis = (addr % 64'(nb)) != 64'd0;
      flt = addr >= (64'd1 << 32);
      e_req = 0; e_stall = 0; e_wb = 0; e_exc = 0; e_cause = 2'd0;
      if (!acc) begin
        e_exc = 0;
      end else if (mis || flt) begin
        e_exc = 1; e_cause = mis ? 2'd1 : 2'd2;
      end else if (lat == 0) begin
        e_exc = 1; e_cause = 2'd3; e_req = 64; e_stall = 65;
      end else begin
        e_req = lat; e_stall = lat + 1; e_wb = ld ? 1 : 0;
      end
      chk_n++; if (o.timeout !== 0 || o.exc_n !== e_exc || (e_exc == 1 && o.cause !== e_cause))
        $display("FAIL rand%0d_exc got n=%0d cause=%0d want n=%0d cause=%0d", n, o.exc_n, o.cause, e_exc, e_cause); else pass_n++;
      chk_n++; if (o.req_n !== e_req || o.stall_n !== e_stall || o.wb_n !== e_wb || o.late_req !== 0 || o.unstable !== 0)
        $display("FAIL rand%0d_seq got req=%0d stall=%0d wb=%0d late=%0d unst=%0d want %0d/%0d/%0d/0/0",
                 n, o.req_n, o.stall_n, o.wb_n, o.late_req, o.unstable, e_req, e_stall, e_wb); else pass_n++;
      if (e_req > 0) begin
        ew = (ld || !st) ? 64'd0 : ((64'd1 << nb) - 64'd1);
        chk_n++; if (o.addr !== addr[31:0] || o.dic !== sd || o.rd !== ld || o.wr !== ew[7:0])
          $display("FAIL rand%0d_req got %h/%h/%b/%h want %h/%h/%b/%h", n, o.addr, o.dic, o.rd, o.wr, addr[31:0], sd, ld, ew[7:0]); else pass_n++;
      end
      if (e_wb == 1) begin
        chk_n++; if (o.wb_data !== exp_ext(f3, dat) || o.wb_rd !== ridx)
          $display("FAIL rand%0d_wb got %h rd=%0d want %h rd=%0d", n, o.wb_data, o.wb_rd, exp_ext(f3, dat), ridx); else pass_n++;
      end
      if ($urandom_range(0, 3) == 0) cyc();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got no finish want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_load_basic();
    test_store();
    test_misalign();
    test_fault_ext();
    test_timeout();
    test_reset_mid_req();
    test_random();
    $display("%0d/%0d checks passed", pass_n, chk_n);
    $finish;
  end

endmodule
